// File: rtl/pixel_stream_sched.sv
// Round-robin scheduler sharing one combinational pixel ROM among several image consumers.
// The granted requester receives a full image as a registered valid/ready stream.
module pixel_stream_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned IMG_PIXELS = 784,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned PIX_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_REQ-1:0]  req_i,
    output logic [N_REQ-1:0]  grant_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [PIX_W-1:0]  rom_data_i,
    output logic [PIX_W-1:0]  pix_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              abort_o
);

    localparam int unsigned CNT_W = $clog2(IMG_PIXELS + 1);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StStream, StEnd} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               load;
    logic               xfer;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign load = (!valid_q || pix_ready_i) && (cnt_q < CNT_W'(IMG_PIXELS));
    assign xfer = valid_q && pix_ready_i;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        pix_d    = pix_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StStream;
                    grant_d = N_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            StStream: begin
                // Abort has priority over a last-pixel transfer in the same cycle.
                if (!req_i[owner_q]) begin
                    state_d = StEnd;
                    abort_d = 1'b1;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    pix_d   = '0;
                end else if (xfer && last_q) begin
                    state_d = StEnd;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    pix_d   = '0;
                end else if (load) begin
                    pix_d   = rom_data_i;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == CNT_W'(IMG_PIXELS - 1));
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            StEnd: begin
                state_d  = StIdle;
                grant_d  = '0;
                cnt_d    = '0;
                rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            pix_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            pix_q    <= pix_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    assign grant_o     = grant_q;
    assign rom_addr_o  = ADDR_W'(cnt_q);
    assign pix_o       = pix_q;
    assign pix_valid_o = valid_q;
    assign pix_last_o  = last_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign abort_o     = abort_q;

endmodule

// File: tb/tb_pixel_stream_sched.sv
// Directed bench for pixel_stream_sched: full-throughput, round-robin order, backpressure,
// abort, mid-stream reset and pointer wrap, against a small ROM function.
module tb_pixel_stream_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] pix;
    logic       pix_valid;
    logic       ready = 1'b0;
    logic       pix_last;
    logic       busy;
    logic       done;
    logic       abort;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [9:0] a);
        return (a[7:0] ^ 8'h5A) + {6'b0, a[9:8]};
    endfunction

    assign rom_data = rom_f(rom_addr);

    pixel_stream_sched dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .grant_o     (grant),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data),
        .pix_o       (pix),
        .pix_valid_o (pix_valid),
        .pix_ready_i (ready),
        .pix_last_o  (pix_last),
        .busy_o      (busy),
        .done_o      (done),
        .abort_o     (abort)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 0);
        check_eq({tag, "_valid"}, 32'(pix_valid), 0);
        check_eq({tag, "_last"}, 32'(pix_last), 0);
        check_eq({tag, "_pix"}, 32'(pix), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_pulses"}, 32'({done, abort}), 0);
        check_eq({tag, "_addr"}, 32'(rom_addr), 0);
    endtask

    // Consume one image from the owner exp_grant; optional drop of req or reset after N beats.
    task automatic run_image(input string tag, input logic [3:0] exp_grant, input int ready_pct,
                             input int drop_at, input int reset_at);
        int t = 0;
        int beats = 0;
        int p_err = 0;
        int s_err = 0;
        bit ended = 0;
        bit dropped = 0;
        bit prev_stall = 0;
        logic [7:0] prev_pix = '0;
        logic prev_last = 1'b0;
        while (grant == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        t = 0;
        while (t < 3000 && !ended) begin
            if (done || abort) begin
                ended = 1;
            end else begin
                if (reset_at >= 0 && beats == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero({tag, "_rst"});
                    return;
                end
                if (prev_stall && (pix !== prev_pix || pix_last !== prev_last || pix_valid !== 1'b1))
                    s_err++;
                if (drop_at >= 0 && beats == drop_at && !dropped) begin
                    req     = req & ~exp_grant;
                    ready   = 1'b0;
                    dropped = 1;
                end else begin
                    ready = (ready_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 99) < ready_pct);
                end
                if (pix_valid && ready) begin
                    if (pix !== rom_f(10'(beats))) p_err++;
                    if (pix_last !== (beats == 783)) p_err++;
                    beats++;
                end
                prev_stall = pix_valid && !ready;
                prev_pix   = pix;
                prev_last  = pix_last;
                @(negedge clk);
                t++;
            end
        end
        check_eq({tag, "_ended"}, 32'(ended), 1);
        if (drop_at >= 0) begin
            check_eq({tag, "_abort"}, 32'({abort, done}), 32'b10);
            check_eq({tag, "_beats"}, 32'(beats), 32'(drop_at));
        end else begin
            check_eq({tag, "_done"}, 32'({done, abort}), 32'b10);
            check_eq({tag, "_beats"}, 32'(beats), 784);
        end
        check_eq({tag, "_end_valid"}, 32'({pix_valid, pix_last}), 0);
        check_eq({tag, "_end_busy"}, 32'(busy), 1);
        check_eq({tag, "_seq"}, 32'(p_err), 0);
        check_eq({tag, "_stall"}, 32'(s_err), 0);
        @(negedge clk);
        check_eq({tag, "_post_pulse"}, 32'({done, abort}), 0);
        check_eq({tag, "_post_grant"}, 32'(grant), 0);
        check_eq({tag, "_post_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v_err, l_err, d_err, b_err, p_err;
        do_reset();
        check_all_zero("reset");

        // T1: exact cycle timing at full throughput.
        v_err = 0; l_err = 0; d_err = 0; b_err = 0; p_err = 0;
        ready = 1'b1;
        req   = 4'b0001;
        for (int c = 1; c <= 787; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check_eq("t1_grant_c1", 32'(grant), 32'b0001);
                check_eq("t1_valid_c1", 32'(pix_valid), 0);
            end
            if (pix_valid !== (c >= 2 && c <= 785)) v_err++;
            if (c >= 2 && c <= 785 && pix !== rom_f(10'(c - 2))) p_err++;
            if (pix_last !== (c == 785)) l_err++;
            if (done !== (c == 786) || abort !== 1'b0) d_err++;
            if (busy !== (c <= 786)) b_err++;
            if (c == 786) check_eq("t1_done_c786", 32'(done), 1);
            if (c == 787) begin
                check_eq("t1_busy_c787", 32'(busy), 0);
                check_eq("t1_grant_c787", 32'(grant), 0);
            end
        end
        req = '0;
        check_eq("t1_valid_window", 32'(v_err), 0);
        check_eq("t1_pix_seq", 32'(p_err), 0);
        check_eq("t1_last", 32'(l_err), 0);
        check_eq("t1_done_window", 32'(d_err), 0);
        check_eq("t1_busy_window", 32'(b_err), 0);

        // T2: round-robin order with three requesters held.
        do_reset();
        req = 4'b1011;
        run_image("t2a", 4'b0001, 100, -1, -1);
        run_image("t2b", 4'b0010, 100, -1, -1);
        run_image("t2c", 4'b1000, 100, -1, -1);
        run_image("t2d", 4'b0001, 100, -1, -1);
        req = '0;

        // T3: random backpressure.
        do_reset();
        req = 4'b0001;
        run_image("t3", 4'b0001, 50, -1, -1);
        req = '0;

        // T4: owner drops request mid-stream; other requester follows.
        do_reset();
        req = 4'b0011;
        run_image("t4a", 4'b0001, 100, 300, -1);
        run_image("t4b", 4'b0010, 100, -1, -1);
        req = '0;

        // T5: asynchronous reset mid-stream, then a fresh image from address 0.
        do_reset();
        req = 4'b0001;
        run_image("t5a", 4'b0001, 100, -1, 500);
        @(negedge clk);
        check_all_zero("t5_hold");
        rst_n = 1'b1;
        run_image("t5b", 4'b0001, 100, -1, -1);
        req = '0;

        // T6: pointer at 3 after requester 2 finishes; 0110 wraps to 0010 then 0100.
        do_reset();
        req = 4'b0100;
        run_image("t6a", 4'b0100, 100, -1, -1);
        req = 4'b0110;
        run_image("t6b", 4'b0010, 100, -1, -1);
        run_image("t6c", 4'b0100, 100, -1, -1);
        req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
